multi_cycle_ctrl: RTL and testbench
===================================

Name: multi_cycle_ctrl

Overview:
EX-stage issuer and consumer for the multi-cycle MUL/DIV unit.
- Detects DIV/DIVU/MADD/MADDU/MSUB/MSUBU in EX, then drives a stable opcode and operands to the unit.
- Stalls the pipeline until the unit reports done, then commits the 64-bit result into the architectural HI/LO registers.
- Owns HI/LO: serves MTHI/MTLO writes and supplies hilo to the unit and to EX readers.

Parameters:
- TIMEOUT_CYCLES, 64: watchdog limit in BUSY cycles; used only when MC_TIMEOUT_EN is defined.

Ports:
- clk  in  1  clock; all state on posedge.
- rst  in  1  reset, asynchronous, active-high; clears all state.
- exception_flush  in  1  kills the EX-stage instruction.
- inst  in  8  EX opcode, `INST_* codes from defs.v.
- op1  in  32  rs operand.
- op2  in  32  rt operand.
- mc_result  in  64  unit result, {hi,lo}; for DIV this is {remainder,quotient}.
- mc_done  in  1  unit done, level; sampled only in BUSY.
- mc_inst  out  8  registered opcode to the unit; `INST_NOP when not BUSY.
- mc_op1  out  32  latched op1.
- mc_op2  out  32  latched op2.
- hilo_o  out  64  current {HI,LO} to the unit hilo_i.
- hi_o  out  32  architectural HI.
- lo_o  out  32  architectural LO.
- stall_req  out  1  hold IF/ID/EX.
- mc_timeout  out  1  sticky watchdog flag.

Behaviour:
- Reset values: HI=LO=0, mc_inst=`INST_NOP, mc_op1=mc_op2=0, stall_req=0, mc_timeout=0, state=IDLE, pending=0.
- MC op set: DIV, DIVU, MADD, MADDU, MSUB, MSUBU.
- stall_req is combinational: 1 when (IDLE and inst in MC op set and !exception_flush) or state==BUSY; 0 in DONE.
- IDLE:
  - MC op and !flush: latch inst/op1/op2 into mc_inst/mc_op1/mc_op2, go to BUSY.
  - MTHI: HI<=op1. MTLO: LO<=op1. Single cycle, no stall; suppressed when flush=1.
  - Any other inst: no action.
- BUSY:
  - Outputs held stable.
  - mc_done=1 (allowed in the first BUSY cycle): pending<=mc_result, mc_inst<=NOP, go to DONE.
  - exception_flush=1: go to IDLE, mc_inst<=NOP, no HI/LO write. Flush has priority over mc_done in the same cycle.
- DONE (one cycle, stall released so the instruction leaves EX):
  - !exception_flush: {HI,LO}<=pending.
  - Always go to IDLE.
  - inst is ignored in DONE, so the same instruction is never reissued.
- Minimum stall: 2 cycles (issue cycle plus one BUSY cycle). DIV with a 36-cycle unit stalls 37 cycles.
- Back-to-back: an MC op arriving in the cycle after DONE issues normally from IDLE.
- hilo_o is the registered {HI,LO}. A pending result is not forwarded; the DONE cycle precedes any dependent MC op.
- rst mid-operation: immediate return to the reset state; any pending result is discarded.

Optional Feature:
- Macro: MC_TIMEOUT_EN.
- Defined:
  - A BUSY-cycle counter increments each BUSY cycle and clears on BUSY entry.
  - On reaching TIMEOUT_CYCLES without mc_done: mc_timeout<=1 (sticky until rst), mc_inst<=NOP, go to IDLE, no HI/LO write.
- Undefined: no counter is built; mc_timeout is tied 0.

Decomposition:
- defs.v holds:
  - `INST_* opcodes, including `INST_NOP, `INST_MTHI, `INST_MTLO;
  - state encodings `MC_IDLE/`MC_BUSY/`MC_DONE (2 bits);
  - the MC-op-set predicate macro.
- Sub-module hilo_reg:
  - 64-bit HI/LO register with separate hi_we/lo_we and full-64 we;
  - async active-high reset.

Test Plan:
1. rst pulse mid-clock → HI=LO=0, mc_inst=NOP, stall_req=0 immediately, with no clock edge.
2. DIVU op1=100, op2=7; model mc_done after 36 cycles with mc_result={32'd2,32'd14} → stall_req high 37 cycles, low in DONE; next cycle HI=2, LO=14; mc_op1/op2 stable throughout.
3. MTHI op1=32'hDEADBEEF, then MTLO op1=32'h12345678 → HI, then LO, updated one cycle each; stall_req never asserted.
4. DIV issued, exception_flush at BUSY cycle 10 → IDLE next cycle, mc_inst=NOP, HI/LO unchanged. MADD then completes normally with result 64'h1_0000_0003 → HI=1, LO=3.
5. mc_done and exception_flush in the same BUSY cycle → no commit. exception_flush in the DONE cycle → no commit. Both cases: state returns to IDLE.
6. With MC_TIMEOUT_EN and TIMEOUT_CYCLES=8, mc_done held 0 → after 8 BUSY cycles mc_timeout=1, stall_req=0, HI/LO unchanged; flag holds until rst.

Source files
------------

// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and the MC-op predicate for the
// multi-cycle MUL/DIV issue controller.
package multi_cycle_ctrl_pkg;

    // EX-stage opcodes seen by the controller
    localparam logic [7:0] INST_NOP   = 8'h00;
    localparam logic [7:0] INST_MTHI  = 8'h11;
    localparam logic [7:0] INST_MTLO  = 8'h13;
    localparam logic [7:0] INST_DIV   = 8'h1A;
    localparam logic [7:0] INST_DIVU  = 8'h1B;
    localparam logic [7:0] INST_MADD  = 8'h20;
    localparam logic [7:0] INST_MADDU = 8'h21;
    localparam logic [7:0] INST_MSUB  = 8'h24;
    localparam logic [7:0] INST_MSUBU = 8'h25;

    typedef enum logic [1:0] {
        MC_IDLE = 2'd0,
        MC_BUSY = 2'd1,
        MC_DONE = 2'd2
    } mc_state_e;

    // True for opcodes that must be handed to the multi-cycle unit
    function automatic logic is_mc_op(input logic [7:0] op);
        return (op == INST_DIV)  || (op == INST_DIVU)  ||
               (op == INST_MADD) || (op == INST_MADDU) ||
               (op == INST_MSUB) || (op == INST_MSUBU);
    endfunction

endpackage

// File: rtl/multi_cycle_ctrl_hilo_reg.sv
// Architectural HI/LO pair. Single-half writes serve MTHI/MTLO; the full
// 64-bit write commits a multi-cycle result and wins if both are raised.
module hilo_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        hi_we,
    input  logic        lo_we,
    input  logic        we,
    input  logic [31:0] wdata,
    input  logic [63:0] hilo_in,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // HI/LO update: full commit first, then the individual halves
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= 32'd0;
            lo <= 32'd0;
        end else if (we) begin
            hi <= hilo_in[63:32];
            lo <= hilo_in[31:0];
        end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end

endmodule

// File: rtl/multi_cycle_ctrl.sv
// EX-stage issuer/consumer for the multi-cycle MUL/DIV unit. Owns HI/LO.
// Optional watchdog on the BUSY state is built when MC_TIMEOUT_EN is defined;
// otherwise mc_timeout is tied low.
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exception_flush,
    input  logic [7:0]  inst,
    input  logic [31:0] op1,
    input  logic [31:0] op2,
    input  logic [63:0] mc_result,
    input  logic        mc_done,
    output logic [7:0]  mc_inst,
    output logic [31:0] mc_op1,
    output logic [31:0] mc_op2,
    output logic [63:0] hilo_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic        stall_req,
    output logic        mc_timeout
);

    mc_state_e   state, state_nx;
    logic [63:0] pending;
    logic        issue, retire, capture, commit;
    logic        hi_we, lo_we;
    logic        timeout_hit;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= MC_IDLE;
        else     state <= state_nx;
    end

    // Next state, stall and datapath strobes. Flush beats done, done beats
    // the watchdog. DONE ignores inst so the retiring op is never reissued.
    always_comb begin
        state_nx  = state;
        issue     = 1'b0;
        retire    = 1'b0;
        capture   = 1'b0;
        commit    = 1'b0;
        hi_we     = 1'b0;
        lo_we     = 1'b0;
        stall_req = 1'b0;
        case (state)
            MC_IDLE: begin
                if (!exception_flush) begin
                    if (is_mc_op(inst)) begin
                        issue     = 1'b1;
                        stall_req = 1'b1;
                        state_nx  = MC_BUSY;
                    end else if (inst == INST_MTHI) begin
                        hi_we = 1'b1;
                    end else if (inst == INST_MTLO) begin
                        lo_we = 1'b1;
                    end
                end
            end
            MC_BUSY: begin
                stall_req = 1'b1;
                if (exception_flush) begin
                    retire   = 1'b1;
                    state_nx = MC_IDLE;
                end else if (mc_done) begin
                    capture  = 1'b1;
                    retire   = 1'b1;
                    state_nx = MC_DONE;
                end else if (timeout_hit) begin
                    retire   = 1'b1;
                    state_nx = MC_IDLE;
                end
            end
            MC_DONE: begin
                commit   = !exception_flush;
                state_nx = MC_IDLE;
            end
            default: state_nx = MC_IDLE;
        endcase
    end

    // Operand/opcode latch toward the unit and the captured result
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mc_inst <= INST_NOP;
            mc_op1  <= 32'd0;
            mc_op2  <= 32'd0;
            pending <= 64'd0;
        end else begin
            if (issue) begin
                mc_inst <= inst;
                mc_op1  <= op1;
                mc_op2  <= op2;
            end else if (retire) begin
                mc_inst <= INST_NOP;
            end
            if (capture) pending <= mc_result;
        end
    end

    hilo_reg u_hilo (
        .clk     (clk),
        .rst     (rst),
        .hi_we   (hi_we),
        .lo_we   (lo_we),
        .we      (commit),
        .wdata   (op1),
        .hilo_in (pending),
        .hi      (hi_o),
        .lo      (lo_o)
    );

    assign hilo_o = {hi_o, lo_o};

`ifdef MC_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] busy_cnt;
    logic          timeout_q;

    // BUSY-cycle counter, restarted on every issue
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                    busy_cnt <= '0;
        else if (issue)             busy_cnt <= '0;
        else if (state == MC_BUSY)  busy_cnt <= busy_cnt + 1'b1;
    end

    // Counter holds completed BUSY cycles, so the last allowed cycle is N-1
    assign timeout_hit = (busy_cnt == CW'(TIMEOUT_CYCLES - 1));

    // Sticky watchdog flag, cleared only by reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            timeout_q <= 1'b0;
        else if (state == MC_BUSY && !exception_flush && !mc_done && timeout_hit)
            timeout_q <= 1'b1;
    end

    assign mc_timeout = timeout_q;
`else
    // Watchdog absent: the comparison is constant false
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
    assign mc_timeout  = 1'b0;
`endif

endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Directed self-checking bench for multi_cycle_ctrl. Inputs change on the
// falling edge; outputs are sampled 1 ns later, well away from posedge.
module tb_multi_cycle_ctrl;
    import multi_cycle_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        exception_flush;
    logic [7:0]  inst;
    logic [31:0] op1, op2;
    logic [63:0] mc_result;
    logic        mc_done;
    logic [7:0]  mc_inst;
    logic [31:0] mc_op1, mc_op2;
    logic [63:0] hilo_o;
    logic [31:0] hi_o, lo_o;
    logic        stall_req;
    logic        mc_timeout;

    int checks = 0;
    int errors = 0;
    int stall_cnt;

    multi_cycle_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .exception_flush (exception_flush),
        .inst            (inst),
        .op1             (op1),
        .op2             (op2),
        .mc_result       (mc_result),
        .mc_done         (mc_done),
        .mc_inst         (mc_inst),
        .mc_op1          (mc_op1),
        .mc_op2          (mc_op2),
        .hilo_o          (hilo_o),
        .hi_o            (hi_o),
        .lo_o            (lo_o),
        .stall_req       (stall_req),
        .mc_timeout      (mc_timeout)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; exception_flush = 1'b0; inst = INST_NOP;
        op1 = 32'd0; op2 = 32'd0; mc_result = 64'd0; mc_done = 1'b0;

        // Reset state
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_hi",      64'(hi_o), 64'd0);
        check("rst_lo",      64'(lo_o), 64'd0);
        check("rst_mc_inst", 64'(mc_inst), 64'(INST_NOP));
        check("rst_stall",   64'(stall_req), 64'd0);
        check("rst_timeout", 64'(mc_timeout), 64'd0);

        // MTHI then MTLO, no stall
        @(negedge clk); inst = INST_MTHI; op1 = 32'hDEADBEEF; #1;
        check("mthi_stall", 64'(stall_req), 64'd0);
        @(negedge clk); inst = INST_MTLO; op1 = 32'h12345678; #1;
        check("mthi_hi",    64'(hi_o), 64'hDEADBEEF);
        check("mthi_lo",    64'(lo_o), 64'd0);
        check("mtlo_stall", 64'(stall_req), 64'd0);
        @(negedge clk); inst = INST_NOP; #1;
        check("mtlo_lo",   64'(lo_o), 64'h12345678);
        check("mtlo_hilo", hilo_o, 64'hDEADBEEF_12345678);

        // DIVU 100/7, done in BUSY cycle 36 -> 37 stalled cycles
        @(negedge clk); inst = INST_DIVU; op1 = 32'd100; op2 = 32'd7; #1;
        check("divu_issue_stall", 64'(stall_req), 64'd1);
        check("divu_issue_inst",  64'(mc_inst), 64'(INST_NOP));
        stall_cnt = stall_req ? 1 : 0;
        for (int i = 1; i <= 36; i++) begin
            @(negedge clk);
            op1 = 32'hFFFF_FFFF; op2 = 32'd0;
            mc_done = (i == 36); mc_result = {32'd2, 32'd14};
            #1;
            if (stall_req) stall_cnt++;
            check("divu_busy_op1",  64'(mc_op1), 64'd100);
            check("divu_busy_op2",  64'(mc_op2), 64'd7);
            check("divu_busy_inst", 64'(mc_inst), 64'(INST_DIVU));
        end
        @(negedge clk); mc_done = 1'b0; #1;
        check("divu_done_stall", 64'(stall_req), 64'd0);
        check("divu_done_inst",  64'(mc_inst), 64'(INST_NOP));
        check("divu_done_hi",    64'(hi_o), 64'hDEADBEEF);
        check("divu_stall_cnt",  64'(stall_cnt), 64'd37);

        // Back-to-back MADDU right after DONE
        @(negedge clk); inst = INST_MADDU; op1 = 32'd3; op2 = 32'd4; #1;
        check("divu_hi",      64'(hi_o), 64'd2);
        check("divu_lo",      64'(lo_o), 64'd14);
        check("maddu_stall",  64'(stall_req), 64'd1);
        @(negedge clk); mc_done = 1'b1; mc_result = {32'd7, 32'd9}; #1;
        check("maddu_inst",   64'(mc_inst), 64'(INST_MADDU));
        @(negedge clk); mc_done = 1'b0; inst = INST_NOP; #1;
        check("maddu_done_stall", 64'(stall_req), 64'd0);
        @(negedge clk); #1;
        check("maddu_hilo",   hilo_o, {32'd7, 32'd9});

        // DIV flushed in BUSY cycle 10
        @(negedge clk); inst = INST_DIV; op1 = 32'd50; op2 = 32'd3; #1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk); exception_flush = (i == 10); #1;
            check("div_busy_stall", 64'(stall_req), 64'd1);
        end
        @(negedge clk); exception_flush = 1'b0; inst = INST_NOP; #1;
        check("div_flush_stall", 64'(stall_req), 64'd0);
        check("div_flush_inst",  64'(mc_inst), 64'(INST_NOP));
        check("div_flush_hilo",  hilo_o, {32'd7, 32'd9});

        // MADD done in first BUSY cycle (minimum 2-cycle stall)
        @(negedge clk); inst = INST_MADD; op1 = 32'd1; op2 = 32'd3; #1;
        check("madd_issue_stall", 64'(stall_req), 64'd1);
        @(negedge clk); mc_done = 1'b1; mc_result = 64'h1_0000_0003; #1;
        check("madd_busy_stall",  64'(stall_req), 64'd1);
        @(negedge clk); mc_done = 1'b0; inst = INST_NOP; #1;
        check("madd_done_stall",  64'(stall_req), 64'd0);
        @(negedge clk); #1;
        check("madd_hi", 64'(hi_o), 64'd1);
        check("madd_lo", 64'(lo_o), 64'd3);

        // mc_done and flush together: no commit, back to IDLE
        @(negedge clk); inst = INST_MSUB; #1;
        @(negedge clk); mc_done = 1'b1; exception_flush = 1'b1; mc_result = 64'hFFFF_FFFF_FFFF_FFFF; #1;
        @(negedge clk); mc_done = 1'b0; exception_flush = 1'b0; inst = INST_MSUBU; #1;
        check("both_idle_stall", 64'(stall_req), 64'd1);
        check("both_hilo",       hilo_o, 64'h1_0000_0003);

        // Flush in DONE: no commit, back to IDLE
        @(negedge clk); mc_done = 1'b1; mc_result = 64'hAAAA_AAAA_BBBB_BBBB; #1;
        check("msubu_inst", 64'(mc_inst), 64'(INST_MSUBU));
        @(negedge clk); mc_done = 1'b0; exception_flush = 1'b1; inst = INST_NOP; #1;
        check("doneflush_stall", 64'(stall_req), 64'd0);
        @(negedge clk); exception_flush = 1'b0; inst = INST_MTLO; op1 = 32'h55; #1;
        check("doneflush_hilo",  hilo_o, 64'h1_0000_0003);
        @(negedge clk); inst = INST_NOP; #1;
        check("doneflush_mtlo",  hilo_o, 64'h1_0000_0055);

`ifdef MC_TIMEOUT_EN
        // Watchdog: 8 BUSY cycles without mc_done
        @(negedge clk); inst = INST_DIVU; op1 = 32'd9; op2 = 32'd0; #1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk); #1;
            check("wd_busy_stall",   64'(stall_req), 64'd1);
            check("wd_busy_timeout", 64'(mc_timeout), 64'd0);
        end
        @(negedge clk); inst = INST_NOP; #1;
        check("wd_timeout", 64'(mc_timeout), 64'd1);
        check("wd_stall",   64'(stall_req), 64'd0);
        check("wd_inst",    64'(mc_inst), 64'(INST_NOP));
        check("wd_hilo",    hilo_o, 64'h1_0000_0055);
        @(negedge clk); #1;
        check("wd_sticky",  64'(mc_timeout), 64'd1);
`else
        check("no_wd_timeout", 64'(mc_timeout), 64'd0);
`endif

        // Asynchronous reset mid-cycle while BUSY
        @(negedge clk); inst = INST_DIV; op1 = 32'd77; op2 = 32'd5; #1;
        @(negedge clk); #1;
        check("arst_pre_stall", 64'(stall_req), 64'd1);
        check("arst_pre_inst",  64'(mc_inst), 64'(INST_DIV));
        #2; rst = 1'b1; inst = INST_NOP; #1;
        check("arst_hilo",    hilo_o, 64'd0);
        check("arst_inst",    64'(mc_inst), 64'(INST_NOP));
        check("arst_op1",     64'(mc_op1), 64'd0);
        check("arst_stall",   64'(stall_req), 64'd0);
        check("arst_timeout", 64'(mc_timeout), 64'd0);
        @(negedge clk); rst = 1'b0; #1;
        check("arst_post_stall", 64'(stall_req), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
